cnt_down_timer: RTL and testbench
=================================

Name: cnt_down_timer

Overview:
- BCD countdown timer, mm:ss (00:00 to 99:59). It is the down-counting counterpart of the up-counting clock chain.
- Decrements once per 1 Hz tick and propagates a borrow through the digits: sec-ones (mod 10), sec-tens (mod 6), min-ones (mod 10), min-tens (mod 10).
- Supports presetting by increment buttons, start/pause, and raises an alarm on reaching 00:00.
- Sits beside the clock counters and feeds the same 7-seg display mux.

Parameters:
- BUZZ_TICKS, 5, number of 1 Hz ticks the alarm stays asserted unless cancelled.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- CLR_n  input  1  asynchronous active-low reset.
- tick  input  1  one-clk-wide 1 Hz enable pulse.
- start_stop  input  1  one-clk-wide debounced button pulse.
- is_setting  input  1  high = setting mode; enables inc_min/inc_sec.
- inc_min  input  1  one-clk-wide pulse; minutes +1 in setting.
- inc_sec  input  1  one-clk-wide pulse; seconds +1 in setting.
- min_ten  output  4  BCD minutes tens digit.
- min_one  output  4  BCD minutes ones digit.
- sec_ten  output  4  BCD seconds tens digit (0-5).
- sec_one  output  4  BCD seconds ones digit.
- running  output  1  high in RUN state.
- done  output  1  one-clk pulse when count reaches 00:00.
- alarm  output  1  high in ALARM state.

Behaviour:
- Reset (CLR_n low, asynchronous): all digits 0, state IDLE, running/done/alarm 0, alarm tick counter 0. Reset mid-count aborts immediately with no done pulse.
- States and transitions:
  - IDLE: start_stop with value != 00:00 -> RUN. start_stop at 00:00 is ignored.
  - RUN: on tick, decrement by 1 second. start_stop -> PAUSE.
  - PAUSE: value holds; start_stop -> RUN.
  - ALARM: alarm = 1. Leaves to IDLE on start_stop or after BUZZ_TICKS ticks. Value stays 00:00.
- Decrement in RUN (on tick), all digit updates in the same edge:
  - sec_one 0 -> 9 with borrow, else -1.
  - sec_ten 0 -> 5 with borrow, else -1 (only on borrow).
  - min_one 0 -> 9 with borrow, else -1 (only on borrow).
  - min_ten -1 (only on borrow).
- Reaching zero: a tick at 00:01 sets the value to 00:00, the state to ALARM, and done = 1 for exactly one clk, all in that same edge. done is registered and visible in the cycle after the tick edge.
- Simultaneous tick and start_stop in RUN: pause wins; no decrement that cycle. Same rule at 00:01: PAUSE at 00:01, no done.
- Setting: inc_min/inc_sec act only when is_setting = 1 and state is IDLE or PAUSE; otherwise ignored.
  - inc_sec: seconds 00..59 +1, wraps 59 -> 00 with NO carry into minutes.
  - inc_min: minutes 00..99 +1, wraps 99 -> 00.
  - Both pulses in the same cycle: both apply independently.
- is_setting = 1 blocks start_stop in IDLE/PAUSE; the timer cannot start while setting.
- ALARM counter: counts ticks while in ALARM; on the BUZZ_TICKS-th tick, next state is IDLE and alarm drops. start_stop in ALARM -> IDLE at once; start_stop and the final tick together -> IDLE.
- Digits never leave their legal BCD range; no state outside the four listed.
- running = (state == RUN); alarm = (state == ALARM); both registered.

Test Plan:
- Reset, then is_setting = 1, 2x inc_min, 5x inc_sec -> display 02:05. Clear is_setting, start_stop -> running = 1.
- Preset 01:00, RUN, 1 tick -> 00:59 (borrow through sec_ten 0 -> 5, min_one 1 -> 0). Preset 10:00, 1 tick -> 09:59.
- Preset 00:02, RUN, 2 ticks -> 00:00. done high for exactly 1 clk after the 2nd tick; alarm = 1; 5 more ticks -> alarm = 0, IDLE.
- RUN at 00:30, start_stop in the same clk as tick -> PAUSE, value stays 00:30. inc_sec with is_setting = 1 -> 00:31. start_stop -> RUN resumes.
- Setting at 00:59, inc_sec -> 00:00 (minutes unchanged). At 99:xx, inc_min -> 00:xx. inc_min during RUN -> ignored.
- RUN at 00:05, assert CLR_n low asynchronously between clk edges -> outputs 0 immediately, no done. After release, start_stop at 00:00 -> stays IDLE.

Source files
------------

// File: rtl/cnt_down_timer.sv
// cnt_down_timer: BCD mm:ss countdown timer with preset buttons, start/pause and a timed alarm
module cnt_down_timer #(
    parameter int BUZZ_TICKS = 5
) (
    input  logic       clk,
    input  logic       CLR_n,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       is_setting,
    input  logic       inc_min,
    input  logic       inc_sec,
    output logic [3:0] min_ten,
    output logic [3:0] min_one,
    output logic [3:0] sec_ten,
    output logic [3:0] sec_one,
    output logic       running,
    output logic       done,
    output logic       alarm
);
    localparam int CW = $clog2(BUZZ_TICKS + 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   buzz_cnt;
    logic            is_zero, is_one, can_set, can_start, dec, last_buzz;
    logic            running_d, done_d, alarm_d;

    assign is_zero   = {min_ten, min_one, sec_ten, sec_one} == 16'h0000;
    assign is_one    = {min_ten, min_one, sec_ten, sec_one} == 16'h0001;
    assign can_set   = is_setting && (state == IDLE || state == PAUSE);
    assign can_start = start_stop && !is_setting && !is_zero;
    assign dec       = state == RUN && tick && !start_stop;
    assign last_buzz = tick && buzz_cnt == CW'(BUZZ_TICKS - 1);

    // State register; status flags are registered alongside it so they change with the state
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= running_d;
            done    <= done_d;
            alarm   <= alarm_d;
        end
    end

    // Next state: a start_stop in RUN beats a simultaneous tick, so pause wins at 00:01 too
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (can_start) state_nxt = RUN;
            RUN:     if (start_stop) state_nxt = PAUSE;
                     else if (tick && is_one) state_nxt = ALARM;
            PAUSE:   if (can_start) state_nxt = RUN;
            ALARM:   if (start_stop || last_buzz) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode of the upcoming state; done fires on the tick that reaches 00:00
    always_comb begin
        running_d = state_nxt == RUN;
        alarm_d   = state_nxt == ALARM;
        done_d    = dec && is_one;
    end

    // Alarm tick counter restarts whenever ALARM is entered or left
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n)
            buzz_cnt <= '0;
        else
            buzz_cnt <= (state == ALARM && state_nxt == ALARM) ? buzz_cnt + CW'(tick) : '0;
    end

    // Digit chain: borrow-decrement while running, independent wrapping increments while setting
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            min_ten <= 4'd0;
            min_one <= 4'd0;
            sec_ten <= 4'd0;
            sec_one <= 4'd0;
        end else if (dec) begin
            sec_one <= sec_one == 4'd0 ? 4'd9 : sec_one - 4'd1;
            if (sec_one == 4'd0)
                sec_ten <= sec_ten == 4'd0 ? 4'd5 : sec_ten - 4'd1;
            if (sec_one == 4'd0 && sec_ten == 4'd0)
                min_one <= min_one == 4'd0 ? 4'd9 : min_one - 4'd1;
            if (sec_one == 4'd0 && sec_ten == 4'd0 && min_one == 4'd0)
                min_ten <= min_ten - 4'd1;
        end else if (can_set) begin
            if (inc_sec) begin
                sec_one <= sec_one == 4'd9 ? 4'd0 : sec_one + 4'd1;
                if (sec_one == 4'd9)
                    sec_ten <= sec_ten == 4'd5 ? 4'd0 : sec_ten + 4'd1;
            end
            if (inc_min) begin
                min_one <= min_one == 4'd9 ? 4'd0 : min_one + 4'd1;
                if (min_one == 4'd9)
                    min_ten <= min_ten == 4'd9 ? 4'd0 : min_ten + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_cnt_down_timer.sv
// tb_cnt_down_timer: directed and randomized checks of cnt_down_timer against a seconds-count model
module tb_cnt_down_timer;
    localparam int BUZZ = 5;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;

    logic clk = 1'b0, CLR_n = 1'b0, tick = 1'b0, start_stop = 1'b0;
    logic is_setting = 1'b0, inc_min = 1'b0, inc_sec = 1'b0;
    logic [3:0] min_ten, min_one, sec_ten, sec_one;
    logic running, done, alarm;
    logic [18:0] obs;
    int checks = 0, fails = 0;
    int m_st, m_min, m_sec, m_buzz;
    bit m_done;

    cnt_down_timer #(.BUZZ_TICKS(BUZZ)) dut (
        .clk(clk), .CLR_n(CLR_n), .tick(tick), .start_stop(start_stop),
        .is_setting(is_setting), .inc_min(inc_min), .inc_sec(inc_sec),
        .min_ten(min_ten), .min_one(min_one), .sec_ten(sec_ten), .sec_one(sec_one),
        .running(running), .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;
    assign obs = {min_ten, min_one, sec_ten, sec_one, running, done, alarm};

    function automatic logic [18:0] expv();
        logic [3:0] a, b, c, d;
        a = 4'(m_min / 10);
        b = 4'(m_min % 10);
        c = 4'(m_sec / 10);
        d = 4'(m_sec % 10);
        return {a, b, c, d, m_st == M_RUN, m_done, m_st == M_ALARM};
    endfunction

    task automatic mreset();
        m_st = M_IDLE; m_min = 0; m_sec = 0; m_buzz = 0; m_done = 0;
    endtask

    task automatic model(input bit tk, ss, st, im, is_);
        int total;
        bit set_ok;
        set_ok = st && (m_st == M_IDLE || m_st == M_PAUSE);
        total = m_min * 60 + m_sec;
        m_done = 0;
        case (m_st)
            M_IDLE, M_PAUSE: if (ss && !st && total != 0) m_st = M_RUN;
            M_RUN: if (ss) m_st = M_PAUSE;
                   else if (tk) begin
                       total--;
                       m_min = total / 60;
                       m_sec = total % 60;
                       if (total == 0) begin m_st = M_ALARM; m_done = 1; m_buzz = 0; end
                   end
            default: if (ss) m_st = M_IDLE;
                     else if (tk) begin
                         m_buzz++;
                         if (m_buzz == BUZZ) m_st = M_IDLE;
                     end
        endcase
        if (set_ok && is_) m_sec = (m_sec + 1) % 60;
        if (set_ok && im) m_min = (m_min + 1) % 100;
    endtask

    task automatic step(input bit tk, ss, st, im, is_);
        tick = tk; start_stop = ss; is_setting = st; inc_min = im; inc_sec = is_;
        model(tk, ss, st, im, is_);
        @(posedge clk);
        #1;
        tick = 0; start_stop = 0; inc_min = 0; inc_sec = 0; is_setting = 0;
    endtask

    task automatic preset(input int mm, ss);
        CLR_n = 0;
        #3;
        CLR_n = 1;
        mreset();
        for (int i = 0; i < mm; i++) step(0, 0, 1, 1, 0);
        for (int i = 0; i < ss; i++) step(0, 0, 1, 0, 1);
    endtask

    task automatic test_reset();
        #2;
        if (obs !== 19'h0) begin fails++; $display("FAIL reset obs=%h exp=%h", obs, 19'h0); end
        checks++;
        @(posedge clk);
        #1;
        CLR_n = 1;
        mreset();
        step(1, 1, 0, 0, 0);
        if (obs !== 19'h0) begin fails++; $display("FAIL start_at_zero_idle obs=%h exp=%h", obs, 19'h0); end
        checks++;
    endtask

    task automatic test_setting();
        preset(2, 5);
        if (obs[18:3] !== 16'h0205) begin fails++; $display("FAIL set_0205 got=%h exp=0205", obs[18:3]); end
        checks++;
        step(0, 1, 1, 0, 0);
        if (running !== 1'b0) begin fails++; $display("FAIL start_blocked_by_setting got=%b exp=0", running); end
        checks++;
        step(0, 1, 0, 0, 0);
        if (running !== 1'b1 || obs !== expv()) begin fails++; $display("FAIL start_run obs=%h exp=%h", obs, expv()); end
        checks++;
    endtask

    task automatic test_borrow();
        preset(1, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        if (obs[18:3] !== 16'h0059 || obs !== expv()) begin fails++; $display("FAIL borrow_0100 obs=%h exp=%h", obs, expv()); end
        checks++;
        preset(10, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        if (obs[18:3] !== 16'h0959 || obs !== expv()) begin fails++; $display("FAIL borrow_1000 obs=%h exp=%h", obs, expv()); end
        checks++;
    endtask

    task automatic test_alarm();
        preset(0, 2);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        if (done !== 1'b0) begin fails++; $display("FAIL done_early got=%b exp=0", done); end
        checks++;
        step(1, 0, 0, 0, 0);
        if (obs !== {16'h0000, 3'b011}) begin fails++; $display("FAIL reach_zero obs=%h exp=%h", obs, {16'h0000, 3'b011}); end
        checks++;
        step(0, 0, 0, 0, 0);
        if (done !== 1'b0 || alarm !== 1'b1) begin fails++; $display("FAIL done_one_clk done=%b alarm=%b exp 0 1", done, alarm); end
        checks++;
        for (int i = 0; i < BUZZ - 1; i++) begin step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0); end
        if (alarm !== 1'b1) begin fails++; $display("FAIL alarm_hold got=%b exp=1", alarm); end
        checks++;
        step(1, 0, 0, 0, 0);
        if (obs !== 19'h0 || obs !== expv()) begin fails++; $display("FAIL alarm_expire obs=%h exp=%h", obs, 19'h0); end
        checks++;
        preset(0, 1);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        if (obs !== 19'h0) begin fails++; $display("FAIL alarm_cancel obs=%h exp=%h", obs, 19'h0); end
        checks++;
    endtask

    task automatic test_pause();
        preset(0, 30);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        if (obs !== {16'h0030, 3'b000}) begin fails++; $display("FAIL pause_wins obs=%h exp=%h", obs, {16'h0030, 3'b000}); end
        checks++;
        step(0, 0, 1, 0, 1);
        if (obs[18:3] !== 16'h0031) begin fails++; $display("FAIL pause_set got=%h exp=0031", obs[18:3]); end
        checks++;
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        if (obs !== {16'h0030, 3'b100}) begin fails++; $display("FAIL resume obs=%h exp=%h", obs, {16'h0030, 3'b100}); end
        checks++;
        preset(0, 1);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        if (obs !== {16'h0001, 3'b000}) begin fails++; $display("FAIL pause_at_one obs=%h exp=%h", obs, {16'h0001, 3'b000}); end
        checks++;
    endtask

    task automatic test_wrap();
        preset(1, 59);
        step(0, 0, 1, 0, 1);
        if (obs[18:3] !== 16'h0100) begin fails++; $display("FAIL sec_wrap got=%h exp=0100", obs[18:3]); end
        checks++;
        preset(99, 10);
        step(0, 0, 1, 1, 1);
        if (obs[18:3] !== 16'h0011) begin fails++; $display("FAIL min_wrap got=%h exp=0011", obs[18:3]); end
        checks++;
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 1);
        if (obs !== {16'h0011, 3'b100}) begin fails++; $display("FAIL inc_in_run obs=%h exp=%h", obs, {16'h0011, 3'b100}); end
        checks++;
    endtask

    task automatic test_async_reset();
        preset(0, 5);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        #2;
        CLR_n = 0;
        #1;
        if (obs !== 19'h0) begin fails++; $display("FAIL async_clear obs=%h exp=%h", obs, 19'h0); end
        checks++;
        @(posedge clk);
        #1;
        if (done !== 1'b0) begin fails++; $display("FAIL no_done_on_reset got=%b exp=0", done); end
        checks++;
        CLR_n = 1;
        mreset();
        step(0, 1, 0, 0, 0);
        if (obs !== 19'h0) begin fails++; $display("FAIL idle_zero_start obs=%h exp=%h", obs, 19'h0); end
        checks++;
    endtask

    task automatic test_random();
        bit tk, ss, st, im, is_;
        preset(0, 0);
        for (int i = 0; i < 3000; i++) begin
            tk = $urandom_range(0, 2) == 0;
            ss = $urandom_range(0, 11) == 0;
            st = $urandom_range(0, 3) == 0;
            im = $urandom_range(0, 2) == 0;
            is_ = $urandom_range(0, 1) == 0;
            step(tk, ss, st, im, is_);
            if (obs !== expv()) begin fails++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs, expv()); end
            checks++;
        end
    endtask

    initial begin
        mreset();
        test_reset();
        test_setting();
        test_borrow();
        test_alarm();
        test_pause();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
